ifconv_wbq: RTL

IFCONV_WBQ -- requirements
Module: ifconv_wbq

---
 rtl/ifconv_wbq_pkg.sv | 12 +
 rtl/ifconv_wbq.sv | 57 +++++
 2 files changed

// File: rtl/ifconv_wbq_pkg.sv
// ifconv_wbq_pkg: shared depth, result-type codes and queue entry layout for the converter writeback queue
package ifconv_wbq_pkg;
  localparam int WBQ_DEPTH = 4;
  localparam logic [1:0] ptype_sngl = 2'd0;
  localparam logic [1:0] ptype_dbl = 2'd1;
  localparam logic [1:0] ptype_ext = 2'd2;
  typedef struct packed {
    logic [81:0] res;
    logic [1:0] rtyp;
    logic [8:0] tag;
  } wbq_entry_t;
endpackage

// File: rtl/ifconv_wbq.sv
// ifconv_wbq: buffers int-to-float converter results until the writeback port grants them,
// stalling the converter through cvt_clkEn when the queue is full
module ifconv_wbq
  import ifconv_wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_clkEn,
  input  logic                     flush,
  input  logic                     in_en,
  input  logic [81:0]              in_res,
  input  logic [1:0]               in_rtyp,
  input  logic [8:0]               in_tag,
  output logic                     cvt_clkEn,
  output logic                     wb_en,
  output logic [81:0]              wb_res,
  output logic [1:0]               wb_rtyp,
  output logic [8:0]               wb_tag,
  input  logic                     wb_gnt,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  wbq_entry_t mem_q [DEPTH];
  logic push, pop;
  // full/empty come from registered count only, so grant never reaches the converter enable
  assign cvt_clkEn = ext_clkEn & (cnt_q != (AW+1)'(DEPTH));
  assign wb_en = cnt_q != '0;
  assign push = in_en & cvt_clkEn & ~flush;
  assign pop = wb_en & wb_gnt & ~flush;
  assign cnt = cnt_q;
  assign wb_res = mem_q[head_q].res;
  assign wb_rtyp = mem_q[head_q].rtyp;
  assign wb_tag = mem_q[head_q].tag;
  always_comb begin
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{res: in_res, rtyp: in_rtyp, tag: in_tag};
  end
endmodule
